tile_shift_engine: RTL and testbench

- Move responder for the 2048 game datapath.
- The game control FSM pulses `enable` with a direction and the 16-box board. This block slides and merges the board one line per cycle, then returns the new board with `done_move`.
- It also reports whether the board changed (`moved`) and whether a winning tile exists (`win`).
- The control FSM returns from MOVE to WAIT on `done_move`, and loads `boxes_out` into the boxes only when `moved` is 1.

---
 rtl/tile_shift_engine.sv | 179 +++++++++++++++++
 tb/tb_tile_shift_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_shift_engine.sv
// 2048 move responder: slides and merges a captured 4x4 board one line per cycle,
// then reports the resulting board together with moved/win flags.
module tile_shift_engine #(
  parameter int TILE_W    = 4,
  parameter int WIN_VALUE = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            direction,
  input  logic [16*TILE_W-1:0]  boxes_in,
  output logic [16*TILE_W-1:0]  boxes_out,
  output logic                  done_move,
  output logic                  moved,
  output logic                  win,
  output logic                  busy
);

  typedef logic [TILE_W-1:0] tile_t;
  typedef enum logic [1:0] {IDLE = 2'b00, PROC = 2'b01, DONE = 2'b10} state_t;

  localparam tile_t TILE_MAX = {TILE_W{1'b1}};
  localparam tile_t WIN_TILE = tile_t'(WIN_VALUE);

  state_t                state_r;
  tile_t                 work_r [16];
  tile_t                 snap_r [16];
  logic [1:0]            dir_r;
  logic [1:0]            line_r;
  logic [3:0]            idx_s [4];
  logic [4*TILE_W-1:0]   line_in_s;
  logic [4*TILE_W-1:0]   line_out_s;
  logic                  moved_s;
  logic                  win_s;

  // Board index {row,col} of position pos (0 = leading edge) on the given line.
  function automatic logic [3:0] box_index(input logic [1:0] dir, input logic [1:0] line_idx,
                                           input logic [1:0] pos);
    logic [3:0] idx;
    case (dir)
      2'b00:   idx = {pos, line_idx};
      2'b01:   idx = {2'd3 - pos, line_idx};
      2'b10:   idx = {line_idx, pos};
      2'b11:   idx = {line_idx, 2'd3 - pos};
      default: idx = 4'd0;
    endcase
    return idx;
  endfunction

  // Compact, merge each pair at most once (saturating), result stays compact.
  function automatic logic [4*TILE_W-1:0] slide_line(input logic [4*TILE_W-1:0] ln);
    tile_t               c [5];
    tile_t               t;
    logic [2:0]          n;
    logic                skip;
    logic [4*TILE_W-1:0] res;
    for (int k = 0; k < 5; k++) begin
      c[k] = '0;
    end
    res  = '0;
    n    = 3'd0;
    skip = 1'b0;
    for (int j = 0; j < 4; j++) begin
      t = ln[j*TILE_W +: TILE_W];
      if (t != '0) begin
        c[n[1:0]] = t;
        n = n + 3'd1;
      end else begin
        n = n;
      end
    end
    n = 3'd0;
    // c[4] is always empty, so the last pair check never matches.
    for (int j = 0; j < 4; j++) begin
      if (skip) begin
        skip = 1'b0;
      end else if ((c[j] != '0) && (c[j] == c[j+1])) begin
        res[n[1:0]*TILE_W +: TILE_W] = (c[j] == TILE_MAX) ? TILE_MAX : c[j] + tile_t'(1);
        n    = n + 3'd1;
        skip = 1'b1;
      end else if (c[j] != '0) begin
        res[n[1:0]*TILE_W +: TILE_W] = c[j];
        n = n + 3'd1;
      end else begin
        skip = 1'b0;
      end
    end
    return res;
  endfunction

  // Gather the current line from the work register and slide it.
  always_comb begin
    idx_s     = '{default: 4'd0};
    line_in_s = '0;
    for (int k = 0; k < 4; k++) begin
      idx_s[k] = box_index(dir_r, line_r, 2'(k));
      line_in_s[k*TILE_W +: TILE_W] = work_r[idx_s[k]];
    end
    line_out_s = slide_line(line_in_s);
  end

  // Result flags derived from the finished work register.
  always_comb begin
    moved_s = 1'b0;
    win_s   = 1'b0;
    for (int k = 0; k < 16; k++) begin
      moved_s = moved_s | (work_r[k] != snap_r[k]);
      win_s   = win_s | (work_r[k] >= WIN_TILE);
    end
  end

  // Move sequencer; DONE is held for the pulse cycle so a coincident enable is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      line_r    <= 2'd0;
      dir_r     <= 2'd0;
      boxes_out <= '0;
      done_move <= 1'b0;
      moved     <= 1'b0;
      win       <= 1'b0;
      busy      <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        work_r[k] <= '0;
        snap_r[k] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          done_move <= 1'b0;
          if (enable) begin
            for (int k = 0; k < 16; k++) begin
              work_r[k] <= boxes_in[k*TILE_W +: TILE_W];
              snap_r[k] <= boxes_in[k*TILE_W +: TILE_W];
            end
            dir_r   <= direction;
            line_r  <= 2'd0;
            busy    <= 1'b1;
            state_r <= PROC;
          end else begin
            busy <= 1'b0;
          end
        end
        PROC: begin
          busy <= 1'b1;
          for (int k = 0; k < 4; k++) begin
            work_r[idx_s[k]] <= line_out_s[k*TILE_W +: TILE_W];
          end
          line_r <= line_r + 2'd1;
          if (line_r == 2'd3) begin
            state_r <= DONE;
          end else begin
            state_r <= PROC;
          end
        end
        DONE: begin
          if (!done_move) begin
            done_move <= 1'b1;
            moved     <= moved_s;
            win       <= win_s;
            for (int k = 0; k < 16; k++) begin
              boxes_out[k*TILE_W +: TILE_W] <= work_r[k];
            end
          end else begin
            done_move <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          done_move <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_shift_engine.sv
// Scoreboard bench for tile_shift_engine: directed 2048 moves plus random traffic
// checked against a queue-based reference model.
module tb_tile_shift_engine;

  typedef struct {
    logic [63:0] boxes;
    logic        moved;
    logic        win;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [1:0]  direction;
  logic [63:0] boxes_in;
  logic [63:0] boxes_out;
  logic        done_move;
  logic        moved;
  logic        win;
  logic        busy;

  int   cyc      = 0;
  int   last_acc = -100;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  exp_t q[$];

  tile_shift_engine #(.TILE_W(4), .WIN_VALUE(11)) dut (
    .clock(clock), .reset(reset), .enable(enable), .direction(direction),
    .boxes_in(boxes_in), .boxes_out(boxes_out), .done_move(done_move),
    .moved(moved), .win(win), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: each line handled as a list of nonzero tiles, merged front to back.
  function automatic exp_t model(input logic [63:0] b, input logic [1:0] d);
    exp_t e;
    int   g [4][4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        g[r][c] = int'(b[(r*4+c)*4 +: 4]);
    for (int l = 0; l < 4; l++) begin
      int lst[$];
      int res[$];
      int rr [4];
      int cc [4];
      for (int k = 0; k < 4; k++) begin
        case (d)
          2'b00:   begin rr[k] = k;     cc[k] = l;     end
          2'b01:   begin rr[k] = 3 - k; cc[k] = l;     end
          2'b10:   begin rr[k] = l;     cc[k] = k;     end
          default: begin rr[k] = l;     cc[k] = 3 - k; end
        endcase
        if (g[rr[k]][cc[k]] != 0) lst.push_back(g[rr[k]][cc[k]]);
      end
      while (lst.size() > 0) begin
        if (lst.size() >= 2 && lst[0] == lst[1]) begin
          res.push_back(lst[0] >= 15 ? 15 : lst[0] + 1);
          void'(lst.pop_front());
          void'(lst.pop_front());
        end else begin
          res.push_back(lst.pop_front());
        end
      end
      while (res.size() < 4) res.push_back(0);
      for (int k = 0; k < 4; k++) g[rr[k]][cc[k]] = res[k];
    end
    e.boxes = '0;
    e.win   = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        e.boxes[(r*4+c)*4 +: 4] = 4'(g[r][c]);
        if (g[r][c] >= 11) e.win = 1'b1;
      end
    e.moved = (e.boxes != b);
    return e;
  endfunction

  function automatic logic [63:0] put(input logic [63:0] b, input int r, input int c, input int v);
    logic [63:0] o;
    o = b;
    o[(r*4+c)*4 +: 4] = 4'(v);
    return o;
  endfunction

  function automatic logic [63:0] rand_board();
    logic [63:0] b;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 2) == 0)       b[i*4 +: 4] = 4'd0;
      else if ($urandom_range(0, 9) == 0)  b[i*4 +: 4] = 4'($urandom_range(9, 15));
      else                                 b[i*4 +: 4] = 4'($urandom_range(1, 3));
    end
    return b;
  endfunction

  // One cycle of stimulus; the expectation is queued only if the DUT should accept.
  task automatic drive_cycle(input logic en, input logic rst, input logic [63:0] b,
                             input logic [1:0] d, input exp_t e);
    @(negedge clock);
    enable    = en;
    reset     = rst;
    boxes_in  = b;
    direction = d;
    @(posedge clock);
    #1;
    if (rst) begin
      last_acc = -100;
      q.delete();
    end else if (en && cyc >= last_acc + 7) begin
      last_acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic directed(input logic [63:0] b, input logic [1:0] d,
                          input logic [63:0] eb, input logic em, input logic ew);
    exp_t e;
    e.boxes = eb;
    e.moved = em;
    e.win   = ew;
    while (cyc + 1 < last_acc + 7) drive_cycle(1'b0, 1'b0, b, d, e);
    drive_cycle(1'b1, 1'b0, b, d, e);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_boxes_out"}, boxes_out, 64'd0);
    chk({tag, "_moved"}, moved, 1'b0);
    chk({tag, "_win"}, win, 1'b0);
    chk({tag, "_done"}, done_move, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Monitor: busy/done timing from the acceptance cycle, results from the scoreboard.
  initial begin
    exp_t e;
    int   dt;
    forever begin
      @(posedge clock);
      #2;
      dt = cyc - last_acc;
      chk("busy", busy, (last_acc >= 0 && dt >= 0 && dt <= 5));
      chk("done_move", done_move, (last_acc >= 0 && dt == 5));
      if (done_move === 1'b1) begin
        chk("expect_available", (q.size() > 0), 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("boxes_out", boxes_out, e.boxes);
          chk("moved", moved, e.moved);
          chk("win", win, e.win);
        end
      end
    end
  end

  initial begin
    logic [63:0] b;
    logic [63:0] eb;
    logic [1:0]  d;
    exp_t        e;
    enable    = 1'b0;
    reset     = 1'b1;
    boxes_in  = '0;
    direction = 2'b00;
    e.boxes = '0; e.moved = 1'b0; e.win = 1'b0;
    repeat (3) drive_cycle(1'b0, 1'b1, 64'd0, 2'b00, e);
    zero_check("reset");

    // Row of four equal tiles, left.
    b = put(put(put(put(64'd0, 0, 0, 1), 0, 1, 1), 0, 2, 1), 0, 3, 1);
    directed(b, 2'b10, put(put(64'd0, 0, 0, 2), 0, 1, 2), 1'b1, 1'b0);
    // No chained merge, left then right.
    b = put(put(put(64'd0, 0, 0, 1), 0, 1, 1), 0, 2, 2);
    directed(b, 2'b10, put(put(64'd0, 0, 0, 2), 0, 1, 2), 1'b1, 1'b0);
    directed(b, 2'b11, put(put(64'd0, 0, 2, 2), 0, 3, 2), 1'b1, 1'b0);
    // Column with gaps, up then down.
    b = put(put(64'd0, 1, 0, 3), 3, 0, 3);
    directed(b, 2'b00, put(64'd0, 0, 0, 4), 1'b1, 1'b0);
    directed(b, 2'b01, put(64'd0, 3, 0, 4), 1'b1, 1'b0);
    // Checkerboard: nothing moves.
    for (int i = 0; i < 16; i++) b[i*4 +: 4] = (((i / 4) + (i % 4)) % 2 == 1) ? 4'd2 : 4'd1;
    directed(b, 2'b10, b, 1'b0, 1'b0);
    // Winning merge and saturation.
    b  = put(put(put(put(64'd0, 2, 0, 10), 2, 1, 10), 3, 0, 15), 3, 1, 15);
    eb = put(put(64'd0, 2, 0, 11), 3, 0, 15);
    directed(b, 2'b10, eb, 1'b1, 1'b1);
    // Pre-existing winner that cannot move, and the empty board.
    directed(put(64'd0, 0, 0, 11), 2'b10, put(64'd0, 0, 0, 11), 1'b0, 1'b1);
    directed(64'd0, 2'b01, 64'd0, 1'b0, 1'b0);

    // Reset during line 2 after a winning move left nonzero outputs behind.
    directed(b, 2'b10, eb, 1'b1, 1'b1);
    repeat (8) drive_cycle(1'b0, 1'b0, b, 2'b10, e);
    directed(b, 2'b11, 64'd0, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b0, b, 2'b10, e);
    drive_cycle(1'b0, 1'b0, b, 2'b10, e);
    drive_cycle(1'b0, 1'b1, b, 2'b10, e);
    zero_check("midmove_reset");
    drive_cycle(1'b0, 1'b0, b, 2'b10, e);

    // Enable held high: one move per IDLE visit, busy-time enables ignored.
    b = rand_board();
    d = 2'($urandom_range(0, 3));
    repeat (20) drive_cycle(1'b1, 1'b0, b, d, model(b, d));

    // Random traffic with inputs changing every cycle.
    for (int i = 0; i < 600; i++) begin
      b = rand_board();
      d = 2'($urandom_range(0, 3));
      drive_cycle(($urandom_range(0, 2) == 0), 1'b0, b, d, model(b, d));
    end

    repeat (10) drive_cycle(1'b0, 1'b0, 64'd0, 2'b00, e);
    chk("scoreboard_drained", q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
